fir_wb_sample_streamer: RTL and testbench
=========================================

// Module: fir_wb_sample_streamer
// PURPOSE
//  Wishbone-classic master that drives one sample at a time through the wishbone-based FIR core.
//  Sits directly upstream of the FIR core, on the same Wishbone bus, as an alternative master to the AXI4-Lite bridge.
//  Per sample: write it to the core, pulse start, poll done, read the result, emit it on a valid/ready stream.
//  Busy-timeout and error reporting keep a hung core from locking the stream.
// PARAMETERS
//  ADDR_W     32       Wishbone address width
//  DATA_W     32       Wishbone data width; the sample and result are the full DATA_W
//  IN_ADDR    'h00     FIR sample-input register address
//  START_ADDR 'h04     FIR start register address (bit0 = start)
//  DONE_ADDR  'h08     FIR status register address (bit0 = done)
//  OUT_ADDR   'h0C     FIR result register address
//  ACK_TMO    256      max cycles stb may wait for ack/err before abort (>=2)
//  POLL_MAX   1024     max done-polls per sample before abort (>=1)
// PORTS
//  clk_i        in   1        clock; Wishbone bus runs on it too
//  rst_i        in   1        asynchronous active-high reset
//  s_valid_i    in   1        input sample valid
//  s_ready_o    out  1        input sample accepted when valid&ready
//  s_data_i     in   DATA_W   input sample
//  m_valid_o    out  1        result valid
//  m_ready_i    in   1        result consumed when valid&ready
//  m_data_o     out  DATA_W   filtered result
//  wb_adr_o     out  ADDR_W   Wishbone address
//  wb_dat_o     out  DATA_W   Wishbone write data
//  wb_sel_o     out  4        byte selects, always 4'hF during a cycle
//  wb_we_o      out  1        write enable
//  wb_cyc_o     out  1        bus cycle
//  wb_stb_o     out  1        strobe
//  wb_dat_i     in   DATA_W   Wishbone read data
//  wb_ack_i     in   1        acknowledge
//  wb_err_i     in   1        bus error
//  busy_o       out  1        FSM not in IDLE
//  err_o        out  1        sticky abort flag
//  err_clr_i    in   1        clears err_o (one-cycle pulse)
//  sample_cnt_o out  16       results emitted, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset values: all outputs 0, FSM in IDLE.
//  s_ready_o = (state==IDLE) && !err_o; a sample is captured on the handshake and the FSM moves to WR_IN.
//  FSM: IDLE -> WR_IN(IN_ADDR, sample) -> WR_SET(START_ADDR, 1) -> WR_CLR(START_ADDR, 0) -> POLL(rd DONE_ADDR)
//       -> [bit0=1] RD_OUT(rd OUT_ADDR) -> EMIT -> IDLE.
//  POLL with bit0=0: the FSM issues the next poll.
//  Bus access: cyc=stb=1 from the first cycle of the bus state; adr/dat/we are stable until ack.
//  ack terminates the access; cyc/stb drop for at least 1 cycle before the next access (no pipelining).
//  Bus cost: 2 cycles per access (1 on the bus + 1 idle) with zero-wait ack.
//  Minimum latency, accept to m_valid_o, is 10 cycles (5 accesses) when done is seen on the first poll.
//  EMIT: m_valid_o=1 with m_data_o held stable until m_ready_i; m_valid_o drops the cycle after the
//   handshake, sample_cnt_o increments, and the FSM goes to IDLE.
//  Abort condition, in any bus state: wb_err_i, ACK_TMO cycles without ack, or POLL_MAX polls without done.
//  On abort: cyc/stb drop, err_o sets, the sample is dropped, and the FSM goes to IDLE.
//  Only err_clr_i clears err_o; while err_o=1, s_ready_o=0.
//  ack and err in the same cycle are treated as err.
//  err_clr_i in the same cycle as a new abort: err_o stays set.
//  wb_ack_i while cyc=0 is ignored. m_ready_i outside EMIT is ignored.
//  Reset mid-transaction forces cyc/stb low immediately (async); any in-flight sample is lost.
// STRUCTURE
//  fir_wb_pkg: state_e enum, FIR register address localparams, WB_SEL_ALL constant.
//  Sub-module wb_single_master: one-shot Wishbone access engine (req/addr/we/wdata in;
//   done/rdata/err out; owns the ACK_TMO counter). The top level holds the FSM, poll counter and stream logic.
// TESTING
//  1 zero-wait slave model, done on first poll, s_data_i=32'h0000_1234 -> bus sequence
//    W00=1234, W04=1, W04=0, R08, R0C; m_data_o=model result 10 cycles after accept; sample_cnt_o=1.
//  2 slave adds 3 wait states per access, done on 4th poll -> 4 R08 accesses; stb held steady through waits; result correct.
//  3 m_ready_i held low for 20 cycles -> m_valid_o/m_data_o stable; s_ready_o=0 throughout; no bus activity.
//  4 slave never acks the W04 access, ACK_TMO=256 -> cyc drops after 256 cycles; err_o=1; s_ready_o=0;
//    after err_clr_i, the next sample completes normally.
//  5 wb_err_i on R0C -> err_o=1, no m_valid_o, sample_cnt_o unchanged.
//  6 async rst_i asserted mid-POLL -> cyc/stb/busy_o=0 in the same cycle; 100 back-to-back samples afterwards:
//    all 100 results in order; sample_cnt_o=100; a preload of 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/fir_wb_pkg.sv
// Shared types and constants for the Wishbone FIR sample streamer.
package fir_wb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrIn,
    StWrSet,
    StWrClr,
    StPoll,
    StRdOut,
    StEmit
  } state_e;

  localparam logic [31:0] FIR_IN_ADDR    = 32'h0000_0000;
  localparam logic [31:0] FIR_START_ADDR = 32'h0000_0004;
  localparam logic [31:0] FIR_DONE_ADDR  = 32'h0000_0008;
  localparam logic [31:0] FIR_OUT_ADDR   = 32'h0000_000C;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_single_master.sv
// One-shot Wishbone classic access engine: holds cyc/stb until ack, err or timeout,
// then reports the outcome for one cycle while the bus idles.
module wb_single_master
  import fir_wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACK_TMO = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int unsigned TW = $clog2(ACK_TMO);
  localparam logic [TW-1:0] TmoLast = TW'(ACK_TMO - 1);

  logic              cyc;
  logic              fin_q, fin_d;
  logic              fin_err_q, fin_err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // The finish cycle doubles as the mandatory idle cycle between accesses.
  always_comb begin
    cyc       = req_i & ~fin_q;
    fin_d     = 1'b0;
    fin_err_d = 1'b0;
    tmo_d     = '0;
    rdata_d   = rdata_q;
    if (cyc) begin
      if (wb_err_i || (!wb_ack_i && tmo_q == TmoLast)) begin
        fin_d     = 1'b1;
        fin_err_d = 1'b1;
      end else if (wb_ack_i) begin
        fin_d   = 1'b1;
        rdata_d = wb_dat_i;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fin_q     <= 1'b0;
      fin_err_q <= 1'b0;
      tmo_q     <= '0;
      rdata_q   <= '0;
    end else begin
      fin_q     <= fin_d;
      fin_err_q <= fin_err_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
    end
  end

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_sel_o = cyc ? WB_SEL_ALL : 4'h0;
  assign wb_adr_o = adr_i;
  assign wb_dat_o = wdata_i;
  assign wb_we_o  = we_i;
  assign done_o   = fin_q & ~fin_err_q;
  assign err_o    = fin_q & fin_err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/fir_wb_sample_streamer.sv
// Wishbone master that pushes each stream sample through the FIR core and streams the result out.
module fir_wb_sample_streamer
  import fir_wb_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] IN_ADDR    = ADDR_W'(FIR_IN_ADDR),
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIR_START_ADDR),
  parameter logic [ADDR_W-1:0] DONE_ADDR  = ADDR_W'(FIR_DONE_ADDR),
  parameter logic [ADDR_W-1:0] OUT_ADDR   = ADDR_W'(FIR_OUT_ADDR),
  parameter int unsigned       ACK_TMO    = 256,
  parameter int unsigned       POLL_MAX   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [15:0]       sample_cnt_o
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] PollLast = PW'(POLL_MAX - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;
  logic              err_q, err_d;

  logic              req, we, abort;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic              eng_done, eng_err;
  logic [DATA_W-1:0] eng_rdata;

  // Gated by rst_i so the input side looks closed while reset is held.
  assign s_ready_o = (state_q == StIdle) && !err_q && !rst_i;

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    result_d     = result_q;
    poll_d       = poll_q;
    sample_cnt_d = sample_cnt_q;
    err_d        = err_q;
    req          = 1'b0;
    adr          = '0;
    we           = 1'b0;
    wdata        = '0;
    abort        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_valid_i && s_ready_o) begin
          sample_d = s_data_i;
          state_d  = StWrIn;
        end
      end
      StWrIn: begin
        req   = 1'b1;
        adr   = IN_ADDR;
        we    = 1'b1;
        wdata = sample_q;
        if (eng_done) state_d = StWrSet;
      end
      StWrSet: begin
        req   = 1'b1;
        adr   = START_ADDR;
        we    = 1'b1;
        wdata = DATA_W'(1);
        if (eng_done) state_d = StWrClr;
      end
      StWrClr: begin
        req = 1'b1;
        adr = START_ADDR;
        we  = 1'b1;
        if (eng_done) begin
          state_d = StPoll;
          poll_d  = '0;
        end
      end
      StPoll: begin
        req = 1'b1;
        adr = DONE_ADDR;
        if (eng_done) begin
          if (eng_rdata[0]) state_d = StRdOut;
          else if (poll_q == PollLast) abort = 1'b1;
          else poll_d = poll_q + 1'b1;
        end
      end
      StRdOut: begin
        req = 1'b1;
        adr = OUT_ADDR;
        if (eng_done) begin
          result_d = eng_rdata;
          state_d  = StEmit;
        end
      end
      StEmit: begin
        if (m_ready_i) begin
          state_d      = StIdle;
          sample_cnt_d = sample_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (eng_err) abort = 1'b1;
    // A fresh abort wins over a simultaneous clear.
    if (abort) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      result_q     <= '0;
      poll_q       <= '0;
      sample_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      result_q     <= result_d;
      poll_q       <= poll_d;
      sample_cnt_q <= sample_cnt_d;
      err_q        <= err_d;
    end
  end

  wb_single_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ACK_TMO(ACK_TMO)
  ) u_wb_master (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req),
    .adr_i   (adr),
    .we_i    (we),
    .wdata_i (wdata),
    .done_o  (eng_done),
    .err_o   (eng_err),
    .rdata_o (eng_rdata),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_we_o (wb_we_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  assign m_valid_o    = (state_q == StEmit);
  assign m_data_o     = result_q;
  assign busy_o       = (state_q != StIdle);
  assign err_o        = err_q;
  assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_fir_wb_sample_streamer.sv
// Directed bench for fir_wb_sample_streamer with a behavioural FIR-core Wishbone slave.
module tb_fir_wb_sample_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_dat_s;
  logic        wb_ack, wb_err;
  logic        busy, err_flag;
  logic        err_clr = 1'b0;
  logic [15:0] sample_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration, driven from the stimulus block.
  int   ws = 0;
  int   done_poll = 1;
  logic hang_start = 1'b0;
  logic err_on_out = 1'b0;

  // Slave and monitor state, owned by the posedge block.
  logic [31:0] sl_in = '0, sl_out = '0;
  int          poll_n = 0, wcnt = 0;
  logic [40:0] log_q[$];
  int          run = 0, last_run = 0, viol = 0, cyc_cnt = 0, sel_bad = 0;
  logic        pend = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;

  always #5 clk = ~clk;

  fir_wb_sample_streamer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel),
    .wb_we_o     (wb_we),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_dat_i    (wb_dat_s),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err),
    .busy_o      (busy),
    .err_o       (err_flag),
    .err_clr_i   (err_clr),
    .sample_cnt_o(sample_cnt)
  );

  function automatic logic [31:0] fir_model(input logic [31:0] x);
    return x * 32'd3 + 32'h11;
  endfunction

  function automatic logic [31:0] stream_word(input int i);
    return 32'h0001_0000 + 32'(i) * 32'd37;
  endfunction

  always_comb begin
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_s = '0;
    if (wb_cyc && wb_stb) begin
      if (err_on_out && wb_adr == 32'hC) wb_err = 1'b1;
      else if (!(hang_start && wb_adr == 32'h4) && wcnt == ws) wb_ack = 1'b1;
      if (wb_adr == 32'h8) wb_dat_s = (poll_n + 1 >= done_poll) ? 32'h1 : 32'h0;
      else if (wb_adr == 32'hC) wb_dat_s = sl_out;
    end
  end

  always @(posedge clk) begin
    if (wb_cyc && wb_stb) begin
      if (wb_ack) begin
        wcnt <= 0;
        log_q.push_back({wb_we, wb_adr[7:0], wb_we ? wb_dat_o : 32'h0});
        if (wb_we && wb_adr == 32'h0) sl_in <= wb_dat_o;
        if (wb_we && wb_adr == 32'h4 && wb_dat_o[0]) begin
          sl_out <= fir_model(sl_in);
          poll_n <= 0;
        end
        if (!wb_we && wb_adr == 32'h8) poll_n <= poll_n + 1;
      end else if (wb_err) begin
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
      run     <= run + 1;
      cyc_cnt <= cyc_cnt + 1;
      if (wb_sel != 4'hF) sel_bad <= sel_bad + 1;
    end else begin
      wcnt <= 0;
      if (run != 0) last_run <= run;
      run <= 0;
    end
    if (pend && !(wb_cyc && wb_stb && wb_adr == p_adr && wb_dat_o == p_dat && wb_we == p_we))
      viol <= viol + 1;
    pend  <= wb_cyc && wb_stb && !wb_ack && !wb_err && !rst;
    p_adr <= wb_adr;
    p_dat <= wb_dat_o;
    p_we  <= wb_we;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offers one sample and returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d);
    int t;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept_wait", 64'(t < 300), 64'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string tag, output int lat);
    lat = 0;
    while (!m_valid && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
    check_eq(tag, 64'(m_valid), 64'd1);
  endtask

  task automatic take();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  logic [40:0] exp1 [0:4];
  int          lat, base, cnt08, bad, t, bad6, tmo6;
  logic [31:0] hold;
  logic        seen;

  initial begin
    exp1 = '{{1'b1, 8'h00, 32'h1234}, {1'b1, 8'h04, 32'h1}, {1'b1, 8'h04, 32'h0},
             {1'b0, 8'h08, 32'h0}, {1'b0, 8'h0C, 32'h0}};

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_s_ready", 64'(s_ready), 64'd0);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_cyc", 64'({wb_cyc, wb_stb, wb_we}), 64'd0);
    check_eq("rst_busy_err", 64'({busy, err_flag}), 64'd0);
    check_eq("rst_cnt", 64'(sample_cnt), 64'd0);
    check_eq("rst_bus", 64'({wb_adr, wb_sel}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_s_ready", 64'(s_ready), 64'd1);

    // 1: zero-wait, done on first poll
    base = log_q.size();
    send(32'h0000_1234);
    wait_mvalid("t1_valid", lat);
    check_eq("t1_latency", 64'(lat), 64'd10);
    check_eq("t1_data", 64'(m_data), 64'(fir_model(32'h1234)));
    check_eq("t1_nacc", 64'(log_q.size() - base), 64'd5);
    if (log_q.size() >= base + 5)
      for (int i = 0; i < 5; i++) check_eq($sformatf("t1_bus%0d", i), 64'(log_q[base+i]),
                                           64'(exp1[i]));
    take();
    check_eq("t1_valid_drop", 64'(m_valid), 64'd0);
    check_eq("t1_cnt", 64'(sample_cnt), 64'd1);

    // 2: three wait states, done on the fourth poll
    ws = 3;
    done_poll = 4;
    base = log_q.size();
    bad = viol;
    send(32'h0000_00AB);
    wait_mvalid("t2_valid", lat);
    check_eq("t2_data", 64'(m_data), 64'(fir_model(32'hAB)));
    cnt08 = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i] == {1'b0, 8'h08, 32'h0}) cnt08++;
    check_eq("t2_polls", 64'(cnt08), 64'd4);
    check_eq("t2_stb_steady", 64'(viol - bad), 64'd0);
    take();
    check_eq("t2_cnt", 64'(sample_cnt), 64'd2);

    // 3: downstream stall
    ws = 0;
    done_poll = 1;
    send(32'h0000_0005);
    wait_mvalid("t3_valid", lat);
    hold = m_data;
    check_eq("t3_data", 64'(hold), 64'(fir_model(32'h5)));
    base = cyc_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!m_valid || m_data != hold || s_ready) bad++;
    end
    check_eq("t3_stall_stable", 64'(bad), 64'd0);
    check_eq("t3_no_bus", 64'(cyc_cnt - base), 64'd0);
    take();
    check_eq("t3_cnt", 64'(sample_cnt), 64'd3);

    // 4: START write never acked
    hang_start = 1'b1;
    send(32'h0000_0077);
    t = 0;
    while (!err_flag && t < 600) begin
      @(posedge clk);
      #1 t++;
    end
    check_eq("t4_err", 64'(err_flag), 64'd1);
    check_eq("t4_tmo_len", 64'(last_run), 64'd256);
    check_eq("t4_idle", 64'({wb_cyc, s_ready, m_valid, busy}), 64'd0);
    hang_start = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("t4_err_clr", 64'(err_flag), 64'd0);
    send(32'h0000_0088);
    wait_mvalid("t4_valid", lat);
    check_eq("t4_data", 64'(m_data), 64'(fir_model(32'h88)));
    take();
    check_eq("t4_cnt", 64'(sample_cnt), 64'd4);

    // 5: bus error on the result read
    err_on_out = 1'b1;
    send(32'h0000_0099);
    t = 0;
    seen = 1'b0;
    while (!err_flag && t < 100) begin
      @(posedge clk);
      #1 t++;
      if (m_valid) seen = 1'b1;
    end
    check_eq("t5_err", 64'(err_flag), 64'd1);
    check_eq("t5_no_valid", 64'(seen), 64'd0);
    check_eq("t5_cnt", 64'(sample_cnt), 64'd4);
    err_on_out = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // 6: async reset mid-poll, then a 100-sample stream
    done_poll = 3;
    send(32'h0000_0042);
    t = 0;
    @(negedge clk);
    while (!(wb_cyc && wb_adr == 32'h8) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("t6_reach_poll", 64'(t < 50), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_rst_async", 64'({wb_cyc, wb_stb, busy}), 64'd0);
    check_eq("t6_rst_cnt", 64'(sample_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_poll = 1;
    bad6 = 0;
    tmo6 = 0;
    fork
      begin
        int tp;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          s_valid = 1'b1;
          s_data  = stream_word(i);
          tp = 0;
          while (!s_ready && tp < 200) begin
            @(negedge clk);
            tp++;
          end
          if (tp >= 200) tmo6++;
          @(posedge clk);
        end
        #1 s_valid = 1'b0;
      end
      begin
        int tc;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          tc = 0;
          while (!m_valid && tc < 200) begin
            @(negedge clk);
            tc++;
          end
          if (tc >= 200) tmo6++;
          else if (m_data != fir_model(stream_word(i))) bad6++;
          @(posedge clk);
        end
        #1 m_ready = 1'b0;
      end
    join
    check_eq("t6_order", 64'(bad6), 64'd0);
    check_eq("t6_stream_tmo", 64'(tmo6), 64'd0);
    check_eq("t6_cnt100", 64'(sample_cnt), 64'd100);

    @(negedge clk);
    force dut.sample_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.sample_cnt_q;
    check_eq("t6_preload", 64'(sample_cnt), 64'hFFFF);
    send(32'h0000_0321);
    wait_mvalid("t6_wrap_valid", lat);
    check_eq("t6_wrap_data", 64'(m_data), 64'(fir_model(32'h321)));
    take();
    check_eq("t6_wrap", 64'(sample_cnt), 64'd0);
    check_eq("sel_all", 64'(sel_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
